vm_sale_controller: RTL and testbench

- Main transaction sequencer for the vending machine.
- Accumulates coin credit, validates a product selection against per-item prices, drives the dispense motor for a fixed time, and returns change through a valid/ack handshake.
- All timing (inactivity timeout, motor on-time) is counted in ticks of the 2 Hz enable produced by the team's clock divider.
- The whole block runs on the fast system clock.

---
 rtl/vm_sale_controller_if.sv | 50 +++++
 rtl/vm_sale_controller.sv | 203 ++++++++++++++++++++
 tb/tb_vm_sale_controller.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vm_sale_controller_if.sv
// Bundles the vending-machine transaction signals between the sale
// controller and its environment (coin acceptor, keypad, motor driver,
// change dispenser).
//   slave  : controller side - consumes strobes/tick/ack, drives status.
//   master : environment side - drives strobes/tick/ack, observes status.
// Signals:
//   tick          2 Hz enable from the clock divider (one cycle wide)
//   coin_valid    coin strobe, coin_type 00=1 01=2 10=5 11=10
//   sel_valid     selection strobe, sel_item = item index
//   cancel        refund request strobe
//   change_ack    change dispenser accepted change_amount
//   credit        current credit
//   coin_reject   pulse, coin returned uncredited
//   sel_deny      pulse, insufficient credit
//   motor_en      dispense motor drive, item_out valid while high
//   change_valid  change request, change_amount held until change_ack
//   timeout       pulse on inactivity refund
//   busy          dispensing or returning change
interface vm_sale_controller_if #(
    parameter int CW = 6
) ();
    logic          tick;
    logic          coin_valid;
    logic [1:0]    coin_type;
    logic          sel_valid;
    logic [1:0]    sel_item;
    logic          cancel;
    logic          change_ack;
    logic [CW-1:0] credit;
    logic          coin_reject;
    logic          sel_deny;
    logic          motor_en;
    logic [1:0]    item_out;
    logic          change_valid;
    logic [CW-1:0] change_amount;
    logic          timeout;
    logic          busy;

    modport slave (
        input  tick, coin_valid, coin_type, sel_valid, sel_item, cancel, change_ack,
        output credit, coin_reject, sel_deny, motor_en, item_out,
               change_valid, change_amount, timeout, busy
    );

    modport master (
        output tick, coin_valid, coin_type, sel_valid, sel_item, cancel, change_ack,
        input  credit, coin_reject, sel_deny, motor_en, item_out,
               change_valid, change_amount, timeout, busy
    );
endinterface

// File: rtl/vm_sale_controller.sv
// Vending machine sale sequencer. Accumulates coin credit, checks a
// selection against its price, runs the dispense motor for DISPENSE_TICKS
// ticks of the 2 Hz enable, and hands change out over a valid/ack
// handshake. Idle credit is refunded after TIMEOUT_TICKS ticks.
// Ports:
//   clk_in   system clock (whole block runs on it)
//   reset_n  asynchronous active-low reset
//   bus      vm_sale_controller_if.slave (strobes in, registered status out)
module vm_sale_controller #(
    parameter int CW             = 6,
    parameter int MAX_CREDIT     = 63,
    parameter int PRICE0         = 15,
    parameter int PRICE1         = 20,
    parameter int PRICE2         = 25,
    parameter int PRICE3         = 30,
    parameter int TIMEOUT_TICKS  = 20,
    parameter int DISPENSE_TICKS = 4
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    vm_sale_controller_if.slave    bus
);
    localparam int CNT_MAX = (TIMEOUT_TICKS > DISPENSE_TICKS) ? TIMEOUT_TICKS : DISPENSE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CW:0]      MAXC = (CW+1)'(MAX_CREDIT);
    localparam logic [CNT_W-1:0] TO_T = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] DS_T = CNT_W'(DISPENSE_TICKS);

    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    credit_q, credit_n, change_q, change_n;
    logic [1:0]       item_q, item_n;
    logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
    logic             motor_q, motor_n;
    logic             reject_q, reject_n;
    logic             deny_q, deny_n;
    logic             timeout_q, timeout_n;
    logic             cvalid_q, cvalid_n;
    logic             busy_q, busy_n;
    logic [CW:0]      coin_val, price, sum;

    // Compare and add one bit wider than credit so nothing wraps.
    always_comb begin
        coin_val = '0;
        case (bus.coin_type)
            2'b00: coin_val = (CW+1)'(1);
            2'b01: coin_val = (CW+1)'(2);
            2'b10: coin_val = (CW+1)'(5);
            2'b11: coin_val = (CW+1)'(10);
            default: coin_val = '0;
        endcase
    end

    always_comb begin
        price = '0;
        case (bus.sel_item)
            2'd0: price = (CW+1)'(PRICE0);
            2'd1: price = (CW+1)'(PRICE1);
            2'd2: price = (CW+1)'(PRICE2);
            2'd3: price = (CW+1)'(PRICE3);
            default: price = '0;
        endcase
    end

    assign sum     = {1'b0, credit_q} + coin_val;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_n   = state;
        credit_n  = credit_q;
        change_n  = change_q;
        item_n    = item_q;
        cnt_n     = cnt_q;
        motor_n   = motor_q;
        reject_n  = 1'b0;
        deny_n    = 1'b0;
        timeout_n = 1'b0;
        cvalid_n  = cvalid_q;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.coin_valid) begin
                    credit_n = coin_val[CW-1:0];
                    state_n  = CREDIT;
                end
                if (bus.sel_valid)
                    deny_n = 1'b1;
            end

            CREDIT: begin
                if (bus.cancel) begin
                    change_n = credit_q;
                    credit_n = '0;
                    cvalid_n = 1'b1;
                    state_n  = CHANGE;
                    reject_n = bus.coin_valid;
                end else if (bus.sel_valid) begin
                    // A selection, granted or denied, wins over a coin and
                    // restarts the inactivity count, so a tick is not counted.
                    reject_n = bus.coin_valid;
                    cnt_n    = '0;
                    if ({1'b0, credit_q} >= price) begin
                        item_n   = bus.sel_item;
                        change_n = credit_q - price[CW-1:0];
                        credit_n = '0;
                        motor_n  = 1'b1;
                        state_n  = DISPENSE;
                    end else begin
                        deny_n = 1'b1;
                    end
                end else if (bus.coin_valid && (sum <= MAXC)) begin
                    credit_n = sum[CW-1:0];
                    cnt_n    = '0;
                end else begin
                    // Rejected coin does not count as activity.
                    reject_n = bus.coin_valid;
                    if (bus.tick) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == TO_T) begin
                            timeout_n = 1'b1;
                            change_n  = credit_q;
                            credit_n  = '0;
                            cvalid_n  = 1'b1;
                            state_n   = CHANGE;
                        end
                    end
                end
            end

            DISPENSE: begin
                reject_n = bus.coin_valid;
                if (bus.tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == DS_T) begin
                        motor_n = 1'b0;
                        cnt_n   = '0;
                        if (change_q != '0) begin
                            cvalid_n = 1'b1;
                            state_n  = CHANGE;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end

            CHANGE: begin
                credit_n = '0;
                reject_n = bus.coin_valid;
                if (cvalid_q && bus.change_ack) begin
                    cvalid_n = 1'b0;
                    change_n = '0;
                    state_n  = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign busy_n = (state_n == DISPENSE) || (state_n == CHANGE);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            credit_q  <= '0;
            change_q  <= '0;
            item_q    <= '0;
            cnt_q     <= '0;
            motor_q   <= 1'b0;
            reject_q  <= 1'b0;
            deny_q    <= 1'b0;
            timeout_q <= 1'b0;
            cvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            credit_q  <= credit_n;
            change_q  <= change_n;
            item_q    <= item_n;
            cnt_q     <= cnt_n;
            motor_q   <= motor_n;
            reject_q  <= reject_n;
            deny_q    <= deny_n;
            timeout_q <= timeout_n;
            cvalid_q  <= cvalid_n;
            busy_q    <= busy_n;
        end
    end

    assign bus.credit        = credit_q;
    assign bus.coin_reject   = reject_q;
    assign bus.sel_deny      = deny_q;
    assign bus.motor_en      = motor_q;
    assign bus.item_out      = item_q;
    assign bus.change_valid  = cvalid_q;
    assign bus.change_amount = change_q;
    assign bus.timeout       = timeout_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_vm_sale_controller.sv
// Directed self-checking bench for vm_sale_controller.
module tb_vm_sale_controller;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    vm_sale_controller_if #(.CW(6)) bus ();

    vm_sale_controller #(
        .CW(6), .MAX_CREDIT(63),
        .PRICE0(15), .PRICE1(20), .PRICE2(25), .PRICE3(30),
        .TIMEOUT_TICKS(20), .DISPENSE_TICKS(4)
    ) dut (
        .clk_in (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        bus.coin_type  = t;
        bus.coin_valid = 1'b1;
        step();
        bus.coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] i);
        bus.sel_item  = i;
        bus.sel_valid = 1'b1;
        step();
        bus.sel_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
    endtask

    task automatic ack();
        bus.change_ack = 1'b1;
        step();
        bus.change_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++; if (bus.credit !== 6'd0) begin fails++; $display("FAIL reset_credit got %0d want 0", bus.credit); end
        tests++; if (bus.motor_en !== 1'b0) begin fails++; $display("FAIL reset_motor got %b want 0", bus.motor_en); end
        tests++; if (bus.change_valid !== 1'b0) begin fails++; $display("FAIL reset_cvalid got %b want 0", bus.change_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.change_amount !== 6'd0) begin fails++; $display("FAIL reset_change got %0d want 0", bus.change_amount); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle();
        select(2'd0);
        tests++; if (bus.sel_deny !== 1'b1) begin fails++; $display("FAIL idle_sel_deny got %b want 1", bus.sel_deny); end
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        tests++; if (bus.sel_deny !== 1'b0) begin fails++; $display("FAIL idle_deny_clear got %b want 0", bus.sel_deny); end
        tests++; if (bus.change_valid !== 1'b0) begin fails++; $display("FAIL idle_cancel got %b want 0", bus.change_valid); end
    endtask

    task automatic test_exact_sale();
        coin(2'b11);
        tests++; if (bus.credit !== 6'd10) begin fails++; $display("FAIL sale_credit10 got %0d want 10", bus.credit); end
        coin(2'b10);
        tests++; if (bus.credit !== 6'd15) begin fails++; $display("FAIL sale_credit15 got %0d want 15", bus.credit); end
        select(2'd0);
        tests++; if (bus.motor_en !== 1'b1) begin fails++; $display("FAIL sale_motor_on got %b want 1", bus.motor_en); end
        tests++; if (bus.item_out !== 2'd0) begin fails++; $display("FAIL sale_item got %0d want 0", bus.item_out); end
        tests++; if (bus.credit !== 6'd0) begin fails++; $display("FAIL sale_credit0 got %0d want 0", bus.credit); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL sale_busy got %b want 1", bus.busy); end
        for (int k = 1; k <= 4; k++) begin
            pulse_tick();
            tests++;
            if (bus.motor_en !== (k < 4)) begin
                fails++; $display("FAIL sale_motor_tick%0d got %b want %b", k, bus.motor_en, (k < 4));
            end
        end
        tests++; if (bus.change_valid !== 1'b0) begin fails++; $display("FAIL sale_no_change got %b want 0", bus.change_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL sale_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_change();
        coin(2'b11); coin(2'b11); coin(2'b10);
        tests++; if (bus.credit !== 6'd25) begin fails++; $display("FAIL chg_credit got %0d want 25", bus.credit); end
        select(2'd1);
        tests++; if (bus.item_out !== 2'd1) begin fails++; $display("FAIL chg_item got %0d want 1", bus.item_out); end
        for (int k = 0; k < 4; k++) pulse_tick();
        tests++; if (bus.motor_en !== 1'b0) begin fails++; $display("FAIL chg_motor_off got %b want 0", bus.motor_en); end
        tests++; if (bus.change_valid !== 1'b1) begin fails++; $display("FAIL chg_valid got %b want 1", bus.change_valid); end
        tests++; if (bus.change_amount !== 6'd5) begin fails++; $display("FAIL chg_amount got %0d want 5", bus.change_amount); end
        step(); step(); step();
        tests++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 6'd5) begin
            fails++; $display("FAIL chg_hold got valid=%b amount=%0d want 1/5", bus.change_valid, bus.change_amount);
        end
        coin(2'b00);
        tests++; if (bus.coin_reject !== 1'b1) begin fails++; $display("FAIL chg_coin_reject got %b want 1", bus.coin_reject); end
        tests++; if (bus.credit !== 6'd0) begin fails++; $display("FAIL chg_credit0 got %0d want 0", bus.credit); end
        ack();
        tests++; if (bus.change_valid !== 1'b0) begin fails++; $display("FAIL chg_ack_valid got %b want 0", bus.change_valid); end
        tests++; if (bus.change_amount !== 6'd0) begin fails++; $display("FAIL chg_ack_amount got %0d want 0", bus.change_amount); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL chg_ack_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_deny();
        coin(2'b11);
        select(2'd3);
        tests++; if (bus.sel_deny !== 1'b1) begin fails++; $display("FAIL deny_pulse got %b want 1", bus.sel_deny); end
        tests++; if (bus.credit !== 6'd10) begin fails++; $display("FAIL deny_credit got %0d want 10", bus.credit); end
        step();
        tests++; if (bus.sel_deny !== 1'b0) begin fails++; $display("FAIL deny_one_cycle got %b want 0", bus.sel_deny); end
        coin(2'b11); coin(2'b11);
        select(2'd3);
        tests++; if (bus.motor_en !== 1'b1 || bus.item_out !== 2'd3) begin
            fails++; $display("FAIL deny_retry got motor=%b item=%0d want 1/3", bus.motor_en, bus.item_out);
        end
        tests++; if (bus.change_amount !== 6'd0) begin fails++; $display("FAIL deny_retry_change got %0d want 0", bus.change_amount); end
        for (int k = 0; k < 4; k++) pulse_tick();
        tests++; if (bus.change_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL deny_retry_idle got cvalid=%b busy=%b want 0/0", bus.change_valid, bus.busy);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 6; k++) coin(2'b11);
        tests++; if (bus.credit !== 6'd60) begin fails++; $display("FAIL ovf_credit60 got %0d want 60", bus.credit); end
        coin(2'b11);
        tests++; if (bus.coin_reject !== 1'b1) begin fails++; $display("FAIL ovf_reject got %b want 1", bus.coin_reject); end
        tests++; if (bus.credit !== 6'd60) begin fails++; $display("FAIL ovf_credit_kept got %0d want 60", bus.credit); end
        coin(2'b01);
        tests++; if (bus.credit !== 6'd62) begin fails++; $display("FAIL ovf_credit62 got %0d want 62", bus.credit); end
        tests++; if (bus.coin_reject !== 1'b0) begin fails++; $display("FAIL ovf_accept got %b want 0", bus.coin_reject); end
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        tests++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 6'd62) begin
            fails++; $display("FAIL ovf_cancel got valid=%b amount=%0d want 1/62", bus.change_valid, bus.change_amount);
        end
        ack();
    endtask

    task automatic test_timeout();
        coin(2'b10); coin(2'b01);
        for (int k = 1; k <= 19; k++) pulse_tick();
        tests++; if (bus.change_valid !== 1'b0 || bus.credit !== 6'd7) begin
            fails++; $display("FAIL to_before got cvalid=%b credit=%0d want 0/7", bus.change_valid, bus.credit);
        end
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        tests++; if (bus.timeout !== 1'b1) begin fails++; $display("FAIL to_pulse got %b want 1", bus.timeout); end
        tests++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 6'd7) begin
            fails++; $display("FAIL to_change got valid=%b amount=%0d want 1/7", bus.change_valid, bus.change_amount);
        end
        step();
        tests++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL to_one_cycle got %b want 0", bus.timeout); end
        ack();

        // Coin at tick 19 restarts the count.
        coin(2'b10); coin(2'b01);
        for (int k = 1; k <= 19; k++) pulse_tick();
        coin(2'b00);
        tests++; if (bus.credit !== 6'd8) begin fails++; $display("FAIL to_restart_credit got %0d want 8", bus.credit); end
        for (int k = 1; k <= 19; k++) begin
            pulse_tick();
            tests++;
            if (bus.change_valid !== 1'b0) begin
                fails++; $display("FAIL to_restart_tick%0d got cvalid=%b want 0", k, bus.change_valid);
            end
        end
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        tests++; if (bus.timeout !== 1'b1 || bus.change_amount !== 6'd8) begin
            fails++; $display("FAIL to_restart_fire got timeout=%b amount=%0d want 1/8", bus.timeout, bus.change_amount);
        end
        ack();
    endtask

    task automatic test_arbitration();
        coin(2'b11); coin(2'b11);
        bus.cancel     = 1'b1;
        bus.sel_valid  = 1'b1;
        bus.sel_item   = 2'd0;
        bus.coin_valid = 1'b1;
        bus.coin_type  = 2'b00;
        step();
        bus.cancel = 1'b0; bus.sel_valid = 1'b0; bus.coin_valid = 1'b0;
        tests++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 6'd20) begin
            fails++; $display("FAIL arb_change got valid=%b amount=%0d want 1/20", bus.change_valid, bus.change_amount);
        end
        tests++; if (bus.coin_reject !== 1'b1) begin fails++; $display("FAIL arb_reject got %b want 1", bus.coin_reject); end
        tests++; if (bus.motor_en !== 1'b0 || bus.sel_deny !== 1'b0) begin
            fails++; $display("FAIL arb_sel_dropped got motor=%b deny=%b want 0/0", bus.motor_en, bus.sel_deny);
        end
        ack();
    endtask

    task automatic test_async_reset();
        coin(2'b11); coin(2'b10);
        select(2'd0);
        pulse_tick();
        tests++; if (bus.motor_en !== 1'b1) begin fails++; $display("FAIL ar_motor_pre got %b want 1", bus.motor_en); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.motor_en !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL ar_immediate got motor=%b busy=%b want 0/0", bus.motor_en, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        select(2'd0);
        tests++; if (bus.sel_deny !== 1'b1 || bus.motor_en !== 1'b0) begin
            fails++; $display("FAIL ar_idle got deny=%b motor=%b want 1/0", bus.sel_deny, bus.motor_en);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.tick = 1'b0; bus.coin_valid = 1'b0; bus.coin_type = 2'b00;
        bus.sel_valid = 1'b0; bus.sel_item = 2'd0; bus.cancel = 1'b0; bus.change_ack = 1'b0;
        #2;
        test_reset();
        test_idle();
        test_exact_sale();
        test_change();
        test_deny();
        test_overflow();
        test_timeout();
        test_arbitration();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
